// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, imem request/ack handshake,
// one-entry skid buffer and IF/ID output register.
module inst_fetch #(
    parameter int INST_ADDR_WIDTH = 16,
    parameter int INST_WIDTH      = 16,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [INST_ADDR_WIDTH-1:0] pc_cur,
    input  logic [INST_ADDR_WIDTH-1:0] pc_next,
    input  logic                       flush,
    output logic                       imem_req,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr,
    input  logic                       imem_ack,
    input  logic [INST_WIDTH-1:0]      imem_rdata,
    input  logic                       stall,
    output logic                       if_valid,
    output logic [INST_WIDTH-1:0]      if_inst,
    output logic [INST_ADDR_WIDTH-1:0] if_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SKID = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t                     state;
    logic [INST_WIDTH-1:0]      skid_inst;
    logic [INST_ADDR_WIDTH-1:0] skid_pc;

    logic ack;
    logic consume;
    logic out_free;

    assign imem_req  = (state == REQ) || (state == DROP);
    assign imem_addr = pc_cur;
    assign ack       = imem_req & imem_ack;
    assign consume   = if_valid & ~stall;
    assign out_free  = ~if_valid | consume;

    // Fetch FSM, PC register, skid buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc_cur    <= RESET_ADDR;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            if_pc     <= '0;
            skid_inst <= '0;
            skid_pc   <= '0;
        end else if (flush) begin
            // A request still in flight must have its data dropped
            if_valid  <= 1'b0;
            skid_inst <= '0;
            skid_pc   <= '0;
            pc_cur    <= pc_next;
            if (imem_req && !imem_ack)
                state <= DROP;
            else
                state <= REQ;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (ack) begin
                        pc_cur <= pc_next;
                        if (out_free) begin
                            if_inst  <= imem_rdata;
                            if_pc    <= pc_cur;
                            if_valid <= 1'b1;
                        end else begin
                            skid_inst <= imem_rdata;
                            skid_pc   <= pc_cur;
                            state     <= SKID;
                        end
                    end else if (consume) begin
                        if_valid <= 1'b0;
                    end
                end
                SKID: begin
                    if (consume) begin
                        if_inst   <= skid_inst;
                        if_pc     <= skid_pc;
                        skid_inst <= '0;
                        skid_pc   <= '0;
                        state     <= REQ;
                    end
                end
                DROP: begin
                    if (consume)
                        if_valid <= 1'b0;
                    if (ack)
                        state <= REQ;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed vector table plus randomized
// run checked against an in-order instruction stream model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_cur;
    logic [15:0] pc_next;
    logic        flush;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        if_valid;
    logic [15:0] if_inst;
    logic [15:0] if_pc;
    logic [15:0] tgt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc_cur     (pc_cur),
        .pc_next    (pc_next),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc)
    );

    // PC adder: sequential +2, or the redirect target on flush
    always_comb begin
        pc_next = pc_cur + 16'd2;
        if (flush)
            pc_next = tgt;
    end

    function automatic logic [15:0] memf(input logic [15:0] a);
        return (a ^ 16'hA5C3) + 16'd7;
    endfunction

    typedef struct {
        logic        rst;
        logic        ack;
        logic        stall;
        logic        flush;
        logic [15:0] tgt;
        logic [15:0] rdata;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic        e_chk;
        logic [15:0] e_pc;
        logic [15:0] e_inst;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic a, input logic s, input logic f,
        input logic [15:0] t, input logic [15:0] d,
        input logic eq, input logic [15:0] ea, input logic ev,
        input logic ec, input logic [15:0] ep, input logic [15:0] ei);
        vec_t v;
        v.rst = r; v.ack = a; v.stall = s; v.flush = f;
        v.tgt = t; v.rdata = d;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev;
        v.e_chk = ec; v.e_pc = ep; v.e_inst = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    int          consumed;
    logic [15:0] exp_pc;
    logic        pend;
    logic [31:0] rnd;

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        stall = 1'b0; flush = 1'b0; tgt = '0;

        //         rst ack st fl tgt      rdata          req addr     v chk pc       inst
        tbl.push_back(mk(0,0,0,0,16'h0,  16'h0,          0,16'h0000,0,1,16'h0000,16'h0000));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'h0),    1,16'h0000,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'h2),    1,16'h0002,1,1,16'h0000,memf(16'h0)));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'h4),    1,16'h0004,1,1,16'h0002,memf(16'h2)));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'h6),    1,16'h0006,1,1,16'h0004,memf(16'h4)));
        tbl.push_back(mk(0,0,0,1,16'h10, 16'h0,          1,16'h0008,1,1,16'h0006,memf(16'h6)));
        tbl.push_back(mk(0,1,0,0,16'h0,  16'hDEAD,       1,16'h0010,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,0,0,0,16'h0,  16'h0,          1,16'h0010,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,0,0,0,16'h0,  16'h0,          1,16'h0010,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,0,16'h0,  16'hA5A5,       1,16'h0010,0,0,16'h0,16'h0));
        tbl.push_back(mk(1,0,0,0,16'h0,  16'h0,          1,16'h0012,1,1,16'h0010,16'hA5A5));
        tbl.push_back(mk(0,0,0,0,16'h0,  16'h0,          0,16'h0000,0,1,16'h0000,16'h0000));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'h0),    1,16'h0000,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'h2),    1,16'h0002,1,1,16'h0000,memf(16'h0)));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'h4),    1,16'h0004,1,1,16'h0002,memf(16'h2)));
        tbl.push_back(mk(0,1,1,0,16'h0,  memf(16'h6),    1,16'h0006,1,1,16'h0004,memf(16'h4)));
        tbl.push_back(mk(0,0,1,0,16'h0,  16'h0,          0,16'h0008,1,1,16'h0004,memf(16'h4)));
        tbl.push_back(mk(0,0,0,0,16'h0,  16'h0,          0,16'h0008,1,1,16'h0004,memf(16'h4)));
        tbl.push_back(mk(0,0,0,0,16'h0,  16'h0,          1,16'h0008,1,1,16'h0006,memf(16'h6)));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'h8),    1,16'h0008,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,0,1,1,16'h100,16'h0,          1,16'h000A,1,1,16'h0008,memf(16'h8)));
        tbl.push_back(mk(0,0,0,0,16'h0,  16'h0,          1,16'h0100,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'hA),    1,16'h0100,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'h100),  1,16'h0100,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,1,1,16'h200,memf(16'h102),  1,16'h0102,1,1,16'h0100,memf(16'h100)));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'h200),  1,16'h0200,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,1,0,16'h0,  memf(16'h202),  1,16'h0202,1,1,16'h0200,memf(16'h200)));
        tbl.push_back(mk(1,0,1,0,16'h0,  16'h0,          0,16'h0204,1,1,16'h0200,memf(16'h200)));
        tbl.push_back(mk(0,0,0,0,16'h0,  16'h0,          0,16'h0000,0,1,16'h0000,16'h0000));
        tbl.push_back(mk(0,1,0,0,16'h0,  memf(16'h0),    1,16'h0000,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,0,0,0,16'h0,  16'h0,          1,16'h0002,1,1,16'h0000,memf(16'h0)));

        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            #1;
            rst        = tbl[i].rst;
            imem_ack   = tbl[i].ack;
            stall      = tbl[i].stall;
            flush      = tbl[i].flush;
            tgt        = tbl[i].tgt;
            imem_rdata = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_chk) begin
                chk($sformatf("v%0d_pc", i), 32'(if_pc), 32'(tbl[i].e_pc));
                chk($sformatf("v%0d_inst", i), 32'(if_inst), 32'(tbl[i].e_inst));
            end
            @(posedge clk);
        end

        // Randomized run: every consumed instruction must be the next one
        // in program order, with the word stored at its address
        #1;
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        exp_pc   = 16'h0000;
        consumed = 0;
        pend     = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            #1;
            rst   = 1'b0;
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            rnd   = $urandom;
            tgt   = rnd[15:0] & 16'hFFFE;
            imem_ack   = imem_req && ($urandom_range(0, 2) != 0);
            imem_rdata = memf(imem_addr);
            @(negedge clk);
            if (pend)
                chk("req_hold", 32'(imem_req), 32'd1);
            if (if_valid && !stall && !flush) begin
                chk("seq_pc", 32'(if_pc), 32'(exp_pc));
                chk("seq_inst", 32'(if_inst), 32'(memf(if_pc)));
                exp_pc = exp_pc + 16'd2;
                consumed++;
            end
            if (flush)
                exp_pc = tgt;
            pend = imem_req && !imem_ack;
            @(posedge clk);
        end
        chk("progress", 32'(consumed >= 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage with the program counter register, instruction-memory request/acknowledge handshake, one-entry skid buffer and IF/ID output register. It sits directly downstream of the PC adder. It presents the current PC to the adder and samples the adder's next-PC result only when a fetch is accepted or a flush occurs. Fetched instructions are delivered to decode with a valid/stall handshake.

## Interface
- INST_ADDR_WIDTH, 16, PC / instruction address width
- INST_WIDTH, 16, instruction word width
- RESET_ADDR, 0, PC value loaded at reset
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_cur  out  INST_ADDR_WIDTH  current PC; drives PC adder pc_in and imem_addr
- pc_next  in  INST_ADDR_WIDTH  next PC from PC adder (sequential, branch target or held)
- flush  in  1  taken branch/redirect; pc_next carries the target this cycle
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  INST_ADDR_WIDTH  fetch address, always equal to pc_cur
- imem_ack  in  1  one-cycle response strobe; only meaningful while imem_req=1
- imem_rdata  in  INST_WIDTH  instruction word, valid with imem_ack
- stall  in  1  decode cannot accept; holds the IF/ID register
- if_valid  out  1  IF/ID register holds a valid instruction
- if_inst  out  INST_WIDTH  fetched instruction
- if_pc  out  INST_ADDR_WIDTH  address of if_inst

## Operation
- States: IDLE, REQ, SKID, DROP.
- Memory rule: once imem_req rises, it stays high until imem_ack. imem_req is 1 in REQ and DROP, and 0 in IDLE and SKID; it is decoded from the state register.
- Consume: decode consumes an instruction when if_valid=1 and stall=0.
- Output free: the output register is free when if_valid=0 or a consume happens this cycle.
- IDLE: moves to REQ on the next cycle unconditionally.
- REQ, ack with output free:
  - if_inst<=imem_rdata, if_pc<=pc_cur, if_valid<=1, pc_cur<=pc_next.
  - Stay in REQ.
- REQ, ack with output not free:
  - Skid buffer captures imem_rdata and pc_cur; pc_cur<=pc_next.
  - Go to SKID.
- REQ, no ack: a consume clears if_valid; pc_cur is held and pc_next is ignored.
- SKID: on consume, the skid contents move into the IF/ID register (if_valid stays 1), then go to REQ. Otherwise hold everything.
- Flush has priority over stall and over normal capture:
  - if_valid<=0, skid discarded, pc_cur<=pc_next.
  - If in REQ without ack this cycle, go to DROP (an old request is in flight). Otherwise go to REQ.
  - An ack in the same cycle as flush is discarded.
- DROP: keep imem_req=1 at the new pc_cur (the address change is tolerated by memory), discard data on ack, then go to REQ.
  - A further flush in DROP updates pc_cur and stays in DROP.
- PC arithmetic is done entirely by the PC adder. This block only registers its result, with wrap-around inherited at INST_ADDR_WIDTH bits.

## Timing
- Reset values: pc_cur=RESET_ADDR, if_valid=0, if_inst=0, if_pc=0, skid cleared, state=IDLE, imem_req=0.
- Cycle after reset release: IDLE, imem_req=0. The following cycle: REQ with imem_addr=RESET_ADDR.
- Latency: an ack in cycle N gives if_valid/if_inst/if_pc in cycle N+1, with the new pc_cur and imem_addr also in N+1.
- With zero-wait memory (ack same cycle as req) and no stall, throughput is one instruction per cycle.
- Reset asserted mid-operation (any state, outstanding request included) returns all registers to reset values on that edge. The memory side must abandon the request.
- Stall asserted with an ack arriving: the instruction is never lost (goes to SKID). At most one fetch is outstanding, and the skid holds at most one entry.

## Test plan
- Reset then zero-wait ack every cycle, pc_next=pc_cur+2, RESET_ADDR=0 -> imem_addr 0,2,4,6; if_pc 0,2,4 on consecutive cycles, each one cycle after its ack.
- 3-cycle ack latency at address 0x0010 with rdata=0xA5A5 -> imem_req held 3 cycles, if_inst=0xA5A5 and if_pc=0x0010 the cycle after ack, pc_cur=0x0012.
- stall=1 while if_valid (if_pc=0x0004) and ack for 0x0006 arrives -> state SKID, imem_req=0, outputs frozen. On stall=0, if_pc=0x0006 next cycle, then a request at 0x0008.
- flush with pc_next=0x0100 while a request to 0x000A is outstanding -> if_valid=0 next cycle, DROP; the 0x000A data is discarded; the next accepted instruction has if_pc=0x0100.
- flush coinciding with ack and stall -> ack data discarded, skid empty, if_valid=0, pc_cur=pc_next.
- rst pulsed in SKID state -> next cycle all outputs at reset values, state IDLE, then a fetch at RESET_ADDR.
